demux13_router: RTL and testbench



---
 rtl/demux13_router_if.sv | 38 +++
 rtl/demux13_router.sv | 117 +++++++++++
 tb/tb_demux13_router.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/demux13_router_if.sv
// Handshake bundle for demux13_router: one valid/ready input channel and three
// valid/ready output channels. The DUT connects through the slave modport.
interface demux13_router_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out2_valid;
  logic             out2_ready;
  logic [WIDTH-1:0] out2_data;

  modport master (
    output in_valid, in_data, in_sel,
    output out0_ready, out1_ready, out2_ready,
    input  in_ready,
    input  out0_valid, out0_data,
    input  out1_valid, out1_data,
    input  out2_valid, out2_data
  );

  modport slave (
    input  in_valid, in_data, in_sel,
    input  out0_ready, out1_ready, out2_ready,
    output in_ready,
    output out0_valid, out0_data,
    output out1_valid, out1_data,
    output out2_valid, out2_data
  );
endinterface

// File: rtl/demux13_router.sv
// Registered 1-to-3 demultiplexer with a one-entry holding register per output.
// Define DEMUX13_DROP_COUNT_EN to count (saturating) beats dropped via in_sel=3.
module demux13_router #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  demux13_router_if.slave      bus,
  output logic [7:0]           drop_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e      state_q [3];
  chan_state_e      state_d [3];
  logic [WIDTH-1:0] data_q  [3];
  logic [WIDTH-1:0] data_d  [3];

  logic [2:0] out_ready;
  logic [2:0] load;
  logic       in_ready_w;
  logic       accept;
  logic       drop;

  always_comb begin
    out_ready = {bus.out2_ready, bus.out1_ready, bus.out0_ready};
  end

  // Ready looks only at the addressed channel so a stalled consumer blocks
  // nothing but its own traffic; never depends on in_valid.
  always_comb begin
    in_ready_w = 1'b1;
    case (bus.in_sel)
      2'd0:    in_ready_w = (state_q[0] == EMPTY) || out_ready[0];
      2'd1:    in_ready_w = (state_q[1] == EMPTY) || out_ready[1];
      2'd2:    in_ready_w = (state_q[2] == EMPTY) || out_ready[2];
      default: in_ready_w = 1'b1;
    endcase
  end

  always_comb begin
    accept = bus.in_valid && in_ready_w;
    drop   = accept && (bus.in_sel == 2'd3);
    load   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      load[i] = accept && (bus.in_sel == 2'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 3; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  // Load wins over drain so a draining channel refills back-to-back.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      if (load[i]) begin
        state_d[i] = FULL;
        data_d[i]  = bus.in_data;
      end else if ((state_q[i] == FULL) && out_ready[i]) begin
        state_d[i] = EMPTY;
      end
    end
  end

  always_comb begin
    bus.in_ready   = in_ready_w;
    bus.out0_valid = (state_q[0] == FULL);
    bus.out1_valid = (state_q[1] == FULL);
    bus.out2_valid = (state_q[2] == FULL);
    bus.out0_data  = data_q[0];
    bus.out1_data  = data_q[1];
    bus.out2_data  = data_q[2];
  end

`ifdef DEMUX13_DROP_COUNT_EN
  logic [7:0] drop_q;
  logic [7:0] drop_d;

  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_demux13_router.sv
// Self-checking bench for demux13_router: table-driven vectors, hand-written
// reset/saturation sequences and random traffic, all scored against per-channel queues.
module tb_demux13_router;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] drop_count;

  demux13_router_if #(.WIDTH(32)) bus ();

  demux13_router #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned drop_model  = 0;
  logic [31:0] sb [3][$];

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [2:0]  rdy;
    logic        exp_ready;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic [1:0] sel, input logic [2:0] rdy);
    if (sel == 2'd3) return 1'b1;
    return (sb[sel].size() == 0) || rdy[sel];
  endfunction

  task automatic check_outputs();
    logic        act_v [3];
    logic [31:0] act_d [3];
    act_v[0] = bus.out0_valid; act_d[0] = bus.out0_data;
    act_v[1] = bus.out1_valid; act_d[1] = bus.out1_data;
    act_v[2] = bus.out2_valid; act_d[2] = bus.out2_data;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("out%0d_valid", n), act_v[n], sb[n].size() != 0);
      if (sb[n].size() != 0) chk($sformatf("out%0d_data", n), act_d[n], sb[n][0]);
    end
`ifdef DEMUX13_DROP_COUNT_EN
    chk("drop_count", drop_count, drop_model);
`else
    chk("drop_count", drop_count, 0);
`endif
  endtask

  // Called at posedge+1; checks at posedge+2, then advances to the next posedge+1.
  task automatic step(input logic v, input logic [1:0] sel, input logic [31:0] d,
                      input logic [2:0] rdy, input logic exp_ready);
    bus.in_valid   = v;
    bus.in_sel     = sel;
    bus.in_data    = d;
    bus.out0_ready = rdy[0];
    bus.out1_ready = rdy[1];
    bus.out2_ready = rdy[2];
    #1;
    chk("in_ready", bus.in_ready, exp_ready);
    check_outputs();
    for (int n = 0; n < 3; n++) begin
      if (sb[n].size() != 0 && rdy[n]) void'(sb[n].pop_front());
    end
    if (v && exp_ready) begin
      if (sel == 2'd3) begin
        if (drop_model < 255) drop_model++;
      end else begin
        sb[sel].push_back(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 32'd100,        3'b111, 1'b1};
    tbl[1]  = '{1'b0, 2'd0, 32'd0,          3'b111, 1'b1};
    tbl[2]  = '{1'b1, 2'd1, 32'd3434343434, 3'b101, 1'b1};
    tbl[3]  = '{1'b1, 2'd1, 32'h55,         3'b101, 1'b0};
    tbl[4]  = '{1'b1, 2'd1, 32'h55,         3'b111, 1'b1};
    tbl[5]  = '{1'b1, 2'd2, 32'd2,          3'b001, 1'b1};
    tbl[6]  = '{1'b0, 2'd2, 32'd0,          3'b001, 1'b0};
    tbl[7]  = '{1'b1, 2'd3, 32'd9,          3'b000, 1'b1};
    tbl[8]  = '{1'b1, 2'd3, 32'd9,          3'b000, 1'b1};
    tbl[9]  = '{1'b1, 2'd3, 32'd9,          3'b000, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 32'd0,          3'b111, 1'b1};
    tbl[11] = '{1'b1, 2'd0, 32'hA,          3'b111, 1'b1};
    tbl[12] = '{1'b1, 2'd0, 32'hB,          3'b111, 1'b1};
    tbl[13] = '{1'b1, 2'd0, 32'hC,          3'b110, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 32'd0,          3'b111, 1'b1};
    tbl[15] = '{1'b0, 2'd3, 32'd0,          3'b111, 1'b1};

    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 2'd0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
    #1;
    chk("rst_out0_data", bus.out0_data, 0);
    chk("rst_out1_data", bus.out1_data, 0);
    chk("rst_out2_data", bus.out2_data, 0);
    check_outputs();
    #11 reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].rdy, tbl[i].exp_ready);
    end

    // Asynchronous reset with out2 holding 7, checked well before the next edge.
    step(1'b1, 2'd2, 32'd7, 3'b011, 1'b1);
    chk("pre_rst_out2_data", bus.out2_data, 7);
    reset = 1'b1;
    #1;
    chk("arst_out2_valid", bus.out2_valid, 0);
    chk("arst_out2_data", bus.out2_data, 0);
    chk("arst_out0_valid", bus.out0_valid, 0);
    chk("arst_out1_valid", bus.out1_valid, 0);
    chk("arst_drop_count", drop_count, 0);
    for (int n = 0; n < 3; n++) sb[n].delete();
    drop_model   = 0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();

    for (int i = 0; i < 200; i++) begin
      logic [1:0]  sel;
      logic [2:0]  rdy;
      sel = 2'($urandom_range(0, 3));
      rdy = 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), sel, $urandom, rdy, model_ready(sel, rdy));
    end

    for (int i = 0; i < 300; i++) begin
      step(1'b1, 2'd3, 32'($urandom), 3'b111, 1'b1);
    end
`ifdef DEMUX13_DROP_COUNT_EN
    chk("drop_saturated", drop_count, 255);
`else
    chk("drop_tied_zero", drop_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
